statemachine: RTL and testbench

- Five-phase sequencer for the multi-cycle RISC-V core.
- Cycles the core through FETCH, DECODE, EXECUTE, MEMORYACCESS and WRITEBACK, one phase per clock.
- Each phase can be held by its stage's stall input.
- Outputs a one-hot phase vector (current), its combinational successor (next), and one decoded enable per phase for the datapath stages.

---
 rtl/statemachine_pkg.sv | 24 ++
 rtl/statemachine.sv | 80 ++++++++
 tb/tb_statemachine.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/statemachine_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : statemachine_pkg
//  Description : Shared core constants for the five-phase sequencer:
//                state width and the one-hot phase encodings.
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package statemachine_pkg;

   // Width of the one-hot phase vector.
   localparam int unsigned c_STATE_W = 5;

   // One-hot phase encodings. Bit position k corresponds to phase k.
   typedef enum logic [c_STATE_W-1:0] {
      FETCH        = 5'b00001,
      DECODE       = 5'b00010,
      EXECUTE      = 5'b00100,
      MEMORYACCESS = 5'b01000,
      WRITEBACK    = 5'b10000
   } state_t;

endpackage : statemachine_pkg
`default_nettype wire

// File: rtl/statemachine.sv
`default_nettype none
// ============================================================================
//  Module      : statemachine
//  Description : Five-phase sequencer for the multi-cycle RISC-V core.
//                Steps FETCH -> DECODE -> EXECUTE -> MEMORYACCESS ->
//                WRITEBACK -> FETCH, one phase per clock. Each phase can be
//                held by its own stall input.
//  Ports       :
//    clk                 in   global clock, rising edge
//    rst_n               in   synchronous reset, ACTIVE-HIGH (name is legacy)
//    stall_<phase>       in   hold <phase> while it is the current phase
//    phase_<phase>       out  high while <phase> is the current phase
//    current[4:0]        out  registered one-hot phase
//    next[4:0]           out  combinational next phase
//  Revision    : 1.0  initial release
// ============================================================================
module statemachine
   import statemachine_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 stall_fetch,
   input  logic                 stall_decode,
   input  logic                 stall_execute,
   input  logic                 stall_memoryaccess,
   input  logic                 stall_writeback,
   output logic                 phase_fetch,
   output logic                 phase_decode,
   output logic                 phase_execute,
   output logic                 phase_memoryaccess,
   output logic                 phase_writeback,
   output logic [c_STATE_W-1:0] current,
   output logic [c_STATE_W-1:0] next
);

   // Kept as a plain vector rather than state_t so that a corrupted,
   // non-one-hot value can exist and be recovered from.
   logic [c_STATE_W-1:0] r_current;
   logic [c_STATE_W-1:0] w_next;

   // ------------------------------------------------------------------------
   // Next-state logic. Only the stall of the current phase is looked at; any
   // value that is not one of the five legal codes falls back to FETCH.
   // ------------------------------------------------------------------------
   always_comb begin
      w_next = FETCH;
      case (r_current)
         FETCH        : w_next = stall_fetch        ? FETCH        : DECODE;
         DECODE       : w_next = stall_decode       ? DECODE       : EXECUTE;
         EXECUTE      : w_next = stall_execute      ? EXECUTE      : MEMORYACCESS;
         MEMORYACCESS : w_next = stall_memoryaccess ? MEMORYACCESS : WRITEBACK;
         WRITEBACK    : w_next = stall_writeback    ? WRITEBACK    : FETCH;
         default      : w_next = FETCH;
      endcase
   end

   // ------------------------------------------------------------------------
   // State register. rst_n is active-high despite its name; it wins over any
   // stall because the stall only acts through w_next.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst_n) begin
         r_current <= FETCH;
      end else begin
         r_current <= w_next;
      end
   end

   // Phase enables follow the state bits directly, no extra latency.
   assign phase_fetch        = r_current[0];
   assign phase_decode       = r_current[1];
   assign phase_execute      = r_current[2];
   assign phase_memoryaccess = r_current[3];
   assign phase_writeback    = r_current[4];

   assign current = r_current;
   assign next    = w_next;

endmodule : statemachine
`default_nettype wire

// File: tb/tb_statemachine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_statemachine
//  Description : Directed self-checking bench for the five-phase sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_statemachine;

   logic       clk;
   logic       rst_n;
   logic [4:0] r_stall;   // [0]=fetch .. [4]=writeback
   logic       phase_fetch, phase_decode, phase_execute;
   logic       phase_memoryaccess, phase_writeback;
   logic [4:0] current;
   logic [4:0] next;

   int n_tests = 0;
   int n_fail  = 0;

   logic [4:0] e_cur;     // bench's expected current phase

   statemachine dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .stall_fetch        (r_stall[0]),
      .stall_decode       (r_stall[1]),
      .stall_execute      (r_stall[2]),
      .stall_memoryaccess (r_stall[3]),
      .stall_writeback    (r_stall[4]),
      .phase_fetch        (phase_fetch),
      .phase_decode       (phase_decode),
      .phase_execute      (phase_execute),
      .phase_memoryaccess (phase_memoryaccess),
      .phase_writeback    (phase_writeback),
      .current            (current),
      .next               (next)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [4:0] succ(input logic [4:0] s);
      case (s)
         5'b00001: return 5'b00010;
         5'b00010: return 5'b00100;
         5'b00100: return 5'b01000;
         5'b01000: return 5'b10000;
         5'b10000: return 5'b00001;
         default : return 5'b00001;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Checks current and the phase vector against the expected state.
   task automatic chk_state(input string tag, input logic [4:0] exp);
      chk({tag, ".current"}, current, exp);
      chk({tag, ".phase"}, {phase_writeback, phase_memoryaccess, phase_execute,
                            phase_decode, phase_fetch}, exp);
   endtask

   // Advance one edge and sample 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Run unstalled until the model reaches the target phase (at most 5 steps).
   task automatic run_to(input logic [4:0] target);
      for (int i = 0; i < 5; i++) begin
         if (e_cur == target) break;
         tick();
         e_cur = succ(e_cur);
      end
      chk_state("run_to", target);
   endtask

   initial begin
      logic [4:0] tgt;
      rst_n   = 1'b1;
      r_stall = 5'b00000;
      e_cur   = 5'b00001;

      // ---- reset held for two edges ----
      tick();
      chk_state("reset_edge1", 5'b00001);
      tick();
      chk_state("reset_edge2", 5'b00001);
      rst_n = 1'b0;
      #1;
      chk_state("reset_released", 5'b00001);
      chk("reset_released.next", next, 5'b00010);

      // ---- first sequence after reset ----
      tick(); chk_state("seq1", 5'b00010);
      tick(); chk_state("seq2", 5'b00100);
      tick(); chk_state("seq3", 5'b01000);
      tick(); chk_state("seq4", 5'b10000);
      tick(); chk_state("seq5", 5'b00001);
      e_cur = 5'b00001;

      // ---- free run, 12 cycles ----
      for (int i = 0; i < 12; i++) begin
         chk("free.next", next, succ(e_cur));
         tick();
         e_cur = succ(e_cur);
         chk_state("free", e_cur);
      end

      // ---- stall hold on each of the five phases ----
      for (int k = 0; k < 5; k++) begin
         tgt = 5'b00001 << k;
         run_to(tgt);
         r_stall = tgt;
         #1;
         for (int c = 0; c < 3; c++) begin
            chk("hold.next", next, tgt);
            tick();
            chk_state("hold", tgt);
         end
         r_stall = 5'b00000;
         #1;
         chk("unhold.next", next, succ(tgt));
         tick();
         e_cur = succ(tgt);
         chk_state("unhold", e_cur);
      end

      // ---- stall of a non-current phase is ignored ----
      run_to(5'b00001);
      r_stall = 5'b00010;
      #1;
      chk("irrel.next", next, 5'b00010);
      tick(); chk_state("irrel.adv", 5'b00010);
      chk("irrel.hold.next", next, 5'b00010);
      tick(); chk_state("irrel.hold", 5'b00010);
      r_stall = 5'b00000;
      e_cur   = 5'b00010;

      // ---- reset beats stall mid-sequence ----
      run_to(5'b01000);
      r_stall = 5'b01000;
      rst_n   = 1'b1;
      tick();
      chk_state("midreset", 5'b00001);
      rst_n   = 1'b0;
      r_stall = 5'b00000;
      e_cur   = 5'b00001;
      tick(); chk_state("midreset.after", 5'b00010);
      e_cur = 5'b00010;

      // ---- illegal state recovery: all-zero ----
      force dut.r_current = 5'b00000;
      #1;
      chk("illegal0.next", next, 5'b00001);
      chk_state("illegal0", 5'b00000);
      release dut.r_current;
      #1;
      tick(); chk_state("illegal0.recover", 5'b00001);
      tick(); chk_state("illegal0.seq", 5'b00010);

      // ---- illegal state recovery: two bits set ----
      force dut.r_current = 5'b00110;
      #1;
      chk("illegal2.next", next, 5'b00001);
      release dut.r_current;
      #1;
      tick(); chk_state("illegal2.recover", 5'b00001);
      tick(); chk_state("illegal2.seq", 5'b00010);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Hard time limit so the run always ends.
   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, observed running expected done");
      $fatal(1, "timeout");
   end

endmodule : tb_statemachine
`default_nettype wire
